// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU (imem, 4x8 register file, ALU/writeback mux).
// Latency: ALU/MOV/NOP 4 cycles FETCH->WB, LDI/JMP/JZ 5 cycles, plus any imem wait cycles.
// Backpressure: imem_valid low holds FETCH/FETCH2 with imem_req/imem_addr stable; HALT is absorbing until reset.
//
// Ports: clk/rst_n (synchronous active-low reset); imem_req/imem_addr/imem_valid/imem_data fetch port;
//   rf_we/rf_waddr/rf_raddr_a/rf_raddr_b register file control; wb_sel/imm writeback mux control;
//   alu_op/alu_zero ALU control and result status; zflag registered zero flag; halted in HALT.
// Optional feature: define CTRL_SINGLE_STEP_EN to add the 'step' input (one instruction per step pulse).
module cpu_ctrl_seq #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic            rf_we,
    output logic [1:0]      rf_waddr,
    output logic [1:0]      rf_raddr_a,
    output logic [1:0]      rf_raddr_b,
    output logic [1:0]      wb_sel,
    output logic [7:0]      imm,
    output logic [2:0]      alu_op,
    input  logic            alu_zero,
    output logic            zflag,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [3:0]      opc;
    logic            is_alu;
    logic            is_write;
    logic            two_byte;
    logic            fetch_ok;
    logic            accept;

    assign opc      = ir[7:4];
    assign is_alu   = (opc >= 4'h2) && (opc <= 4'h6);
    assign is_write = (opc >= OP_MOV) && (opc <= OP_LDI);
    assign two_byte = (opc == OP_LDI) || (opc == OP_JMP) || (opc == OP_JZ);

`ifdef CTRL_SINGLE_STEP_EN
    logic step_pend;
    assign fetch_ok = step_pend;
`else
    assign fetch_ok = 1'b1;
`endif

    // Request is gated by rst_n so nothing is requested while reset is held.
    assign imem_req   = rst_n && (((state == S_FETCH) && fetch_ok) || (state == S_FETCH2));
    assign accept     = imem_req && imem_valid;
    assign imem_addr  = pc;
    assign rf_waddr   = ir[3:2];
    assign rf_raddr_a = ir[3:2];
    assign rf_raddr_b = ir[1:0];

    always_comb begin
        alu_op = 3'd0;
        case (opc)
            4'h3:    alu_op = 3'd1;
            4'h4:    alu_op = 3'd2;
            4'h5:    alu_op = 3'd3;
            4'h6:    alu_op = 3'd4;
            default: alu_op = 3'd0;
        endcase
    end

    always_comb begin
        wb_sel = 2'd0;
        if (opc == OP_LDI)
            wb_sel = 2'd1;
        else if (opc == OP_MOV)
            wb_sel = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            imm    <= '0;
            zflag  <= 1'b0;
            rf_we  <= 1'b0;
            halted <= 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
            step_pend <= 1'b0;
`endif
        end else begin
`ifdef CTRL_SINGLE_STEP_EN
            // Accepting the opcode byte consumes the pending step; a step that
            // arrives while one is already pending is simply absorbed.
            if (state == S_FETCH && accept)
                step_pend <= 1'b0;
            else if (step)
                step_pend <= 1'b1;
`endif
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        ir    <= imem_data;
                        pc    <= pc + PC_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opc == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (two_byte) begin
                        state <= S_FETCH2;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_FETCH2: begin
                    if (accept) begin
                        imm   <= imem_data;
                        pc    <= pc + PC_W'(1);
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // rf_we is registered so it is high for exactly the WB cycle.
                    rf_we <= is_write;
                    state <= S_WB;
                end
                S_WB: begin
                    rf_we <= 1'b0;
                    if (is_alu)
                        zflag <= alu_zero;
                    // JZ tests the flag as it stood before this WB.
                    if ((opc == OP_JMP) || ((opc == OP_JZ) && zflag))
                        pc <= PC_W'(imm);
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: random programs against an instruction-level reference model, plus directed cases.
// Latency: n/a (bench). The bench supplies imem with random or fixed wait states, the register file and the ALU.
// Backpressure: imem_valid is withheld for a programmable number of cycles per fetch.
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic [1:0] wb_sel;
    logic [7:0] imm;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       zflag;
    logic       halted;
`ifdef CTRL_SINGLE_STEP_EN
    logic       step;
`endif

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .wb_sel     (wb_sel),
        .imm        (imm),
        .alu_op     (alu_op),
        .alu_zero   (alu_zero),
        .zflag      (zflag),
        .halted     (halted)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bench datapath: register file + ALU + wb mux ----------------
    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] op_a, op_b, alu_res, wb_val;

    always_comb begin
        op_a    = rf[rf_raddr_a];
        op_b    = rf[rf_raddr_b];
        alu_res = 8'h00;
        case (alu_op)
            3'd0:    alu_res = op_a + op_b;
            3'd1:    alu_res = op_a - op_b;
            3'd2:    alu_res = op_a & op_b;
            3'd3:    alu_res = op_a | op_b;
            3'd4:    alu_res = op_a ^ op_b;
            default: alu_res = 8'h00;
        endcase
        alu_zero = (alu_res == 8'h00);
        wb_val   = 8'h00;
        case (wb_sel)
            2'd0:    wb_val = alu_res;
            2'd1:    wb_val = imm;
            2'd2:    wb_val = op_b;
            default: wb_val = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (rf_we)
            rf[rf_waddr] <= wb_val;
    end

    // ---------------- instruction memory responder ----------------
    logic [7:0] mem [256];
    int  fixed_wait = -1;   // >=0 forces that many wait cycles per fetch
    int  max_wait   = 0;    // random wait upper bound otherwise
    int  wait_left  = -1;
    bit  glitch     = 1'b0; // drive imem_valid regardless of imem_req

    initial begin
        imem_valid = 1'b0;
        imem_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (glitch) begin
                imem_valid = 1'b1;
                imem_data  = 8'($urandom);
            end else if (!imem_req) begin
                imem_valid = 1'b0;
                wait_left  = -1;
            end else begin
                if (wait_left < 0)
                    wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
                if (wait_left == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                    wait_left  = -1;
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 8'($urandom);
                    wait_left--;
                end
            end
        end
    end

    // ---------------- instruction-level reference model ----------------
    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         lat;    // cycles from opcode accept to the write, excluding waits
    } wr_t;

    logic [7:0] fq [$];     // expected fetch addresses
    wr_t        wq [$];     // expected register writes
    logic [7:0] flog [$];   // accepted fetch addresses, for directed checks
    logic [7:0] m_r [4];
    logic [7:0] m_pc;
    logic       m_z;
    bit         m_halt;
    int         n_instr;
    int         n_we;

    task automatic model_step();
        logic [7:0] op, im, res;
        logic [3:0] o;
        logic [1:0] x, y;
        wr_t        w;
        op = mem[m_pc];
        fq.push_back(m_pc);
        m_pc = m_pc + 8'd1;
        o = op[7:4];
        x = op[3:2];
        y = op[1:0];
        im = 8'h00;
        if (o == 4'h7 || o == 4'h8 || o == 4'h9) begin
            im = mem[m_pc];
            fq.push_back(m_pc);
            m_pc = m_pc + 8'd1;
        end
        res = 8'h00;
        case (o)
            4'h1: begin w.addr = x; w.data = m_r[y]; w.lat = 3; wq.push_back(w); m_r[x] = m_r[y]; end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                if (o == 4'h2) res = m_r[x] + m_r[y];
                if (o == 4'h3) res = m_r[x] - m_r[y];
                if (o == 4'h4) res = m_r[x] & m_r[y];
                if (o == 4'h5) res = m_r[x] | m_r[y];
                if (o == 4'h6) res = m_r[x] ^ m_r[y];
                m_z = (res == 8'h00);
                w.addr = x; w.data = res; w.lat = 3; wq.push_back(w);
                m_r[x] = res;
            end
            4'h7: begin w.addr = x; w.data = im; w.lat = 4; wq.push_back(w); m_r[x] = im; end
            4'h8: m_pc = im;
            4'h9: if (m_z) m_pc = im;
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
        n_instr++;
    endtask

    int         cyc = 0;
    int         t0 = 0;
    int         waits = 0;
    bit         waiting = 1'b0;
    logic [7:0] hold_addr, hold_imm;

    task automatic mon_reset();
        fq.delete();
        wq.delete();
        flog.delete();
        for (int i = 0; i < 4; i++) m_r[i] = rf[i];
        m_pc    = 8'h00;
        m_z     = 1'b0;
        m_halt  = 1'b0;
        n_instr = 0;
        n_we    = 0;
        waiting = 1'b0;
        waits   = 0;
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (imem_req && !imem_valid) begin
                    if (waiting) begin
                        check_val("wait_addr_hold", imem_addr, hold_addr);
                        check_val("wait_imm_hold", imm, hold_imm);
                    end else begin
                        waiting   = 1'b1;
                        hold_addr = imem_addr;
                        hold_imm  = imm;
                    end
                    waits++;
                end else begin
                    waiting = 1'b0;
                end
                if (imem_req && imem_valid) begin
                    flog.push_back(imem_addr);
                    if (fq.size() == 0) begin
                        check_val("zflag", zflag, m_z);
                        if (m_halt)
                            check_val("fetch_after_halt", 1, 0);
                        else
                            model_step();
                        t0    = cyc;
                        waits = 0;
                    end
                    if (fq.size() > 0)
                        check_val("fetch_addr", imem_addr, fq.pop_front());
                end
                if (rf_we) begin
                    n_we++;
                    if (wq.size() == 0) begin
                        check_val("spurious_rf_we", 1, 0);
                    end else begin
                        e = wq.pop_front();
                        check_val("wb_addr", rf_waddr, e.addr);
                        check_val("wb_data", wb_val, e.data);
                        check_val("latency", cyc - t0 - waits, e.lat);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic load_prog_clear();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic apply_reset(input logic exp_req);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_imem_req", imem_req, 0);
        check_val("rst_imem_addr", imem_addr, 8'h00);
        check_val("rst_rf_we", rf_we, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_zflag", zflag, 0);
        check_val("rst_imm", imm, 8'h00);
        check_val("rst_wb_sel", wb_sel, 2'd0);
        #2;
        mon_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("first_req", imem_req, exp_req);
        check_val("first_addr", imem_addr, 8'h00);
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check_val("halt_reached", halted, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b, saved_addr;
        int         guard;
        rst_n = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif

        // Random programs (no HALT bytes anywhere) with random wait states.
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7] = 1'b0;
            mem[i] = b;
        end
        max_wait = 2;
        apply_reset(1'b1);
        guard = 0;
        while (n_instr < 300 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check_val("random_progress", (n_instr >= 300) ? 1 : 0, 1);
        max_wait = 0;

        // LDI R1,5; LDI R2,5; SUB R1,R2; HALT
        load_prog_clear();
        mem[0] = 8'h74; mem[1] = 8'h05; mem[2] = 8'h78; mem[3] = 8'h05; mem[4] = 8'h36; mem[5] = 8'hF0;
        apply_reset(1'b1);
        run_until_halt(200);
        check_val("sub_we_count", n_we, 3);
        check_val("sub_r1", rf[1], 8'h00);
        check_val("sub_zflag", zflag, 1);
        saved_addr = imem_addr;
        glitch = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("halt_req", imem_req, 0);
            check_val("halt_stays", halted, 1);
            check_val("halt_addr", imem_addr, saved_addr);
        end
        glitch = 1'b0;

        // SUB R1,R1 (z=1); JZ 0x10 -> taken
        load_prog_clear();
        mem[0] = 8'h35; mem[1] = 8'h90; mem[2] = 8'h10;
        apply_reset(1'b1);
        run_until_halt(200);
        check_val("jz_taken_addr", (flog.size() > 3) ? flog[3] : 8'hXX, 8'h10);

        // LDI R1,5; ADD R1,R1 (z=0); JZ 0x10 -> falls through to 0x05
        load_prog_clear();
        mem[0] = 8'h74; mem[1] = 8'h05; mem[2] = 8'h25; mem[3] = 8'h90; mem[4] = 8'h10;
        apply_reset(1'b1);
        run_until_halt(200);
        check_val("jz_not_taken_addr", (flog.size() > 5) ? flog[5] : 8'hXX, 8'h05);

        // JMP 0xFE; NOP at 0xFE; JMP at 0xFF whose imm byte wraps to address 0x00 (=0x80)
        load_prog_clear();
        mem[0] = 8'h80; mem[1] = 8'hFE; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h80;
        apply_reset(1'b1);
        run_until_halt(200);
        check_val("wrap_imm_fetch", (flog.size() > 4) ? flog[4] : 8'hXX, 8'h00);
        check_val("wrap_target", (flog.size() > 5) ? flog[5] : 8'hXX, 8'h80);

        // LDI R3,0xA5 with three wait cycles on every fetch
        load_prog_clear();
        mem[0] = 8'h7C; mem[1] = 8'hA5;
        fixed_wait = 3;
        apply_reset(1'b1);
        run_until_halt(200);
        check_val("wait_imm", imm, 8'hA5);
        check_val("wait_r3", rf[3], 8'hA5);
        fixed_wait = -1;

        // LDI R1,0; ADD R1,R1 (would set z) -- reset lands during its WB
        load_prog_clear();
        mem[0] = 8'h74; mem[1] = 8'h00; mem[2] = 8'h25;
        apply_reset(1'b1);
        guard = 0;
        while (!(rf_we && wb_sel == 2'd0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("wb_add_seen", (rf_we && wb_sel == 2'd0) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("wbrst_rf_we", rf_we, 0);
        check_val("wbrst_zflag", zflag, 0);
        check_val("wbrst_pc", imem_addr, 8'h00);
        check_val("wbrst_req", imem_req, 0);
        check_val("wbrst_halted", halted, 0);

`ifdef CTRL_SINGLE_STEP_EN
        // Two step pulses -> exactly two ADDs retire.
        load_prog_clear();
        mem[0] = 8'h25; mem[1] = 8'h2A; mem[2] = 8'h25;
        step = 1'b0;
        apply_reset(1'b0);
        guard = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) guard++;
        end
        check_val("step_idle_req", guard, 0);
        repeat (2) begin
            #2;
            step = 1'b1;
            @(negedge clk);
            #2;
            step = 1'b0;
            repeat (15) @(negedge clk);
        end
        check_val("step_two_instr", n_we, 2);
        check_val("step_not_halted", halted, 0);
        step = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
